// File: rtl/counter_pkg.sv
// Shared constants for the modulo counter: direction and mode encodings plus
// the legal parameter ranges.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;
  localparam int unsigned PRE_W_MIN = 1;
  localparam int unsigned PRE_W_MAX = 16;

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of the modulo counter. The master drives the
// controls and observes the registered count, tc and ovf.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 8
);

  logic             en;
  logic             dir;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [PRE_W-1:0] prescale;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, dir, sat, load, load_val, limit, prescale, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  en, dir, sat, load, load_val, limit, prescale, clr_ovf,
    output count, tc, ovf
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: raises step once every prescale+1 enabled cycles; restart
// forces the phase back to zero.
module tick_gen
  import counter_pkg::*;
#(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [PRE_W-1:0] prescale,
  output logic             step
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  // A phase above a newly lowered prescale free-runs through all-ones to 0.
  assign step = en && (pre_cnt_q == prescale);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (restart) begin
      pre_cnt_d = '0;
    end else if (step) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter over 0..limit with wrap or saturate, synchronous
// load, prescaled stepping, terminal-count pulse and sticky overflow.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  mod_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             event_hit;

  tick_gen #(
    .PRE_W (PRE_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .restart  (bus.load),
    .prescale (bus.prescale),
    .step     (step)
  );

  always_comb begin
    count_d   = count_q;
    event_hit = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    end else if (step) begin
      if (bus.dir == DIR_UP) begin
        if (count_q < bus.limit) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          // Also catches a stale count left above a lowered limit.
          event_hit = 1'b1;
          count_d   = (bus.sat == MODE_SAT) ? bus.limit : '0;
        end
      end else begin
        if (count_q > bus.limit) begin
          count_d = bus.limit;
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          event_hit = 1'b1;
          count_d   = (bus.sat == MODE_SAT) ? '0 : bus.limit;
        end
      end
    end
    tc_d  = event_hit;
    // A set on the same edge as a clear wins.
    ovf_d = event_hit | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: vector tables, directed corner sequences and a
// randomized run against an arithmetic reference model.
module tb_mod_counter;
  import counter_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned P = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state.
  int m_count, m_pre, m_tc, m_ovf;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(W), .PRE_W(P)) bus ();

  mod_counter #(
    .WIDTH (W),
    .PRE_W (P)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic en, dir, sat, load, clr;
    int   lv, lim, ps;
    int   e_count, e_tc, e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic dir, input logic sat, input logic load,
                       input logic clr, input int lv, input int lim, input int ps);
    bus.en       = en;
    bus.dir      = dir;
    bus.sat      = sat;
    bus.load     = load;
    bus.clr_ovf  = clr;
    bus.load_val = W'(lv);
    bus.limit    = W'(lim);
    bus.prescale = P'(ps);
  endtask

  task automatic model_reset();
    m_count = 0;
    m_pre   = 0;
    m_tc    = 0;
    m_ovf   = 0;
  endtask

  // Spec rules in plain integer arithmetic, evaluated on the current inputs.
  task automatic model_edge();
    int  lim, lv, ps, pre_n;
    bit  stp, ev;
    lim   = int'(bus.limit);
    lv    = int'(bus.load_val);
    ps    = int'(bus.prescale);
    ev    = 1'b0;
    stp   = bus.en && (m_pre == ps);
    pre_n = m_pre;
    if (bus.en) pre_n = stp ? 0 : (m_pre + 1) % (1 << P);
    if (bus.load) begin
      pre_n   = 0;
      m_count = (lv < lim) ? lv : lim;
    end else if (stp) begin
      if (bus.dir) begin
        if (m_count < lim) m_count = m_count + 1;
        else begin
          ev      = 1'b1;
          m_count = bus.sat ? lim : 0;
        end
      end else begin
        if (m_count > lim) m_count = lim;
        else if (m_count > 0) m_count = m_count - 1;
        else begin
          ev      = 1'b1;
          m_count = bus.sat ? 0 : lim;
        end
      end
    end
    m_tc  = ev ? 1 : 0;
    m_ovf = ev ? 1 : (bus.clr_ovf ? 0 : m_ovf);
    m_pre = pre_n;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic en, input logic dir, input logic sat, input logic load,
                     input logic clr, input int lv, input int lim, input int ps,
                     input int ec, input int et, input int eo);
    vec_t v;
    v.en = en; v.dir = dir; v.sat = sat; v.load = load; v.clr = clr;
    v.lv = lv; v.lim = lim; v.ps = ps;
    v.e_count = ec; v.e_tc = et; v.e_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].dir, vecs[i].sat, vecs[i].load, vecs[i].clr,
            vecs[i].lv, vecs[i].lim, vecs[i].ps);
      tick();
      check($sformatf("%s[%0d].count", tag, i), int'(bus.count), vecs[i].e_count);
      check($sformatf("%s[%0d].tc", tag, i), int'(bus.tc), vecs[i].e_tc);
      check($sformatf("%s[%0d].ovf", tag, i), int'(bus.ovf), vecs[i].e_ovf);
    end
    vecs.delete();
  endtask

  initial begin
    int lim_r, ps_r;
    drive(1'b0, DIR_UP, MODE_WRAP, 1'b0, 1'b0, 0, 9, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.count", int'(bus.count), 0);
    check("reset.tc", int'(bus.tc), 0);
    check("reset.ovf", int'(bus.ovf), 0);
    rst_n = 1'b1;

    // Wrap up over 0..9 with a step every cycle, then load 5.
    for (int k = 1; k <= 9; k++) add(1, DIR_UP, MODE_WRAP, 0, 0, 0, 9, 0, k, 0, 0);
    add(1, DIR_UP, MODE_WRAP, 0, 0, 0, 9, 0, 0, 1, 1);
    add(1, DIR_UP, MODE_WRAP, 0, 0, 0, 9, 0, 1, 0, 1);
    add(1, DIR_UP, MODE_WRAP, 0, 0, 0, 9, 0, 2, 0, 1);
    add(1, DIR_UP, MODE_WRAP, 1, 0, 5, 9, 0, 5, 0, 1);
    run_table("wrap");

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.count", int'(bus.count), 0);
    check("async_rst.tc", int'(bus.tc), 0);
    check("async_rst.ovf", int'(bus.ovf), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Load restarts the prescaler, clamps to limit and beats a pending step.
    add(1, DIR_UP, MODE_SAT, 0, 0, 0, 6, 2, 0, 0, 0);
    add(1, DIR_UP, MODE_SAT, 1, 0, 3, 6, 2, 3, 0, 0);
    add(1, DIR_UP, MODE_SAT, 0, 0, 0, 6, 2, 3, 0, 0);
    add(1, DIR_UP, MODE_SAT, 0, 0, 0, 6, 2, 3, 0, 0);
    add(1, DIR_UP, MODE_SAT, 1, 0, 12, 6, 2, 6, 0, 0);
    add(1, DIR_UP, MODE_SAT, 0, 0, 0, 6, 2, 6, 0, 0);
    add(1, DIR_UP, MODE_SAT, 0, 0, 0, 6, 2, 6, 0, 0);
    add(1, DIR_UP, MODE_SAT, 0, 0, 0, 6, 2, 6, 1, 1);
    add(1, DIR_UP, MODE_SAT, 0, 0, 0, 6, 2, 6, 0, 1);
    run_table("load");

    // Clear without an event.
    drive(1'b0, DIR_UP, MODE_SAT, 1'b0, 1'b1, 0, 6, 2);
    tick();
    check("clr.ovf", int'(bus.ovf), 0);
    check("clr.count", int'(bus.count), 6);

    // Saturating down count with prescale 2 from 2.
    drive(1'b1, DIR_DOWN, MODE_SAT, 1'b1, 1'b0, 2, 9, 2);
    tick();
    check("satdn.load", int'(bus.count), 2);
    drive(1'b1, DIR_DOWN, MODE_SAT, 1'b0, 1'b0, 0, 9, 2);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("satdn[%0d].count", i), int'(bus.count), (i < 3) ? 2 : (i < 6) ? 1 : 0);
      check($sformatf("satdn[%0d].tc", i), int'(bus.tc), (i == 9 || i == 12) ? 1 : 0);
      check($sformatf("satdn[%0d].ovf", i), int'(bus.ovf), (i >= 9) ? 1 : 0);
    end

    // Count left above a lowered limit.
    drive(1'b1, DIR_UP, MODE_WRAP, 1'b1, 1'b0, 8, 15, 0);
    tick();
    check("lower.load", int'(bus.count), 8);
    drive(1'b1, DIR_UP, MODE_WRAP, 1'b0, 1'b0, 8, 3, 0);
    tick();
    check("lower_up.count", int'(bus.count), 0);
    check("lower_up.tc", int'(bus.tc), 1);
    check("lower_up.ovf", int'(bus.ovf), 1);
    drive(1'b1, DIR_DOWN, MODE_WRAP, 1'b1, 1'b1, 8, 15, 0);
    tick();
    check("lower.reload", int'(bus.count), 8);
    check("lower.reload_ovf", int'(bus.ovf), 0);
    drive(1'b1, DIR_DOWN, MODE_WRAP, 1'b0, 1'b0, 8, 3, 0);
    tick();
    check("lower_dn.count", int'(bus.count), 3);
    check("lower_dn.tc", int'(bus.tc), 0);
    check("lower_dn.ovf", int'(bus.ovf), 0);

    // Enable low freezes both count and prescaler phase.
    drive(1'b1, DIR_UP, MODE_WRAP, 1'b1, 1'b0, 4, 9, 5);
    tick();
    drive(1'b1, DIR_UP, MODE_WRAP, 1'b0, 1'b0, 0, 9, 5);
    repeat (2) tick();
    drive(1'b0, DIR_UP, MODE_WRAP, 1'b0, 1'b0, 0, 9, 5);
    repeat (10) tick();
    check("freeze.count", int'(bus.count), 4);
    check("freeze.tc", int'(bus.tc), 0);
    drive(1'b1, DIR_UP, MODE_WRAP, 1'b0, 1'b0, 0, 9, 5);
    repeat (3) tick();
    check("resume.before", int'(bus.count), 4);
    tick();
    check("resume.step", int'(bus.count), 5);

    // Event and clear on the same edge.
    drive(1'b1, DIR_UP, MODE_WRAP, 1'b1, 1'b0, 9, 9, 0);
    tick();
    drive(1'b1, DIR_UP, MODE_WRAP, 1'b0, 1'b1, 0, 9, 0);
    tick();
    check("race.count", int'(bus.count), 0);
    check("race.tc", int'(bus.tc), 1);
    check("race.ovf", int'(bus.ovf), 1);
    drive(1'b1, DIR_UP, MODE_WRAP, 1'b0, 1'b0, 0, 9, 0);
    tick();
    check("race.tc_drop", int'(bus.tc), 0);
    check("race.ovf_hold", int'(bus.ovf), 1);

    // Randomized run against the model.
    lim_r = 9;
    ps_r  = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0)
        lim_r = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) ps_r = int'($urandom_range(0, 3));
      drive(logic'($urandom_range(0, 99) < 85), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 99) < 5),
            logic'($urandom_range(0, 99) < 5), int'($urandom_range(0, 15)), lim_r, ps_r);
      tick();
      check($sformatf("rand[%0d].count", c), int'(bus.count), m_count);
      check($sformatf("rand[%0d].tc", c), int'(bus.tc), m_tc);
      check($sformatf("rand[%0d].ovf", c), int'(bus.ovf), m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
